// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake and operand/result bus for serial_adder
//   master: start, a, b, cin out; busy, done, sum, cout (and ovf) in
//   slave : mirror of master
//   OVERFLOW_FLAG_EN adds the ovf result signal
interface serial_adder_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef OVERFLOW_FLAG_EN
    logic             ovf;
    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one full-adder cell plus carry flop, LSB first
//   clk, rst : clock and synchronous active-high reset
//   bus      : serial_adder_if.slave (start/a/b/cin in; busy/done/sum/cout out)
//   OVERFLOW_FLAG_EN: adds registered signed-overflow flag bus.ovf
module serial_adder #(parameter int WIDTH = 8) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic             r_cout;
    logic             w_bit;
    logic             w_carry;
    logic             w_load;
    logic             w_last;
    assign w_bit   = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_carry = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
    assign w_load  = bus.start && (r_state != SHIFT);
    assign w_last  = r_cnt == CW'(WIDTH - 1);
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
`ifdef OVERFLOW_FLAG_EN
    logic r_ovf;
    assign bus.ovf = r_ovf;
    always_ff @(posedge clk) begin
        if (rst)
            r_ovf <= 1'b0;
        else if (r_state == SHIFT && w_last)
            r_ovf <= r_carry ^ w_carry;
    end
`endif
    // r_a doubles as the result shift register: each sum bit enters the MSB
    // as the consumed operand bit leaves the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_a     <= bus.a;
                r_b     <= bus.b;
                r_carry <= bus.cin;
                r_cnt   <= '0;
                r_state <= SHIFT;
                r_busy  <= 1'b1;
            end else if (r_state == SHIFT) begin
                r_a     <= {w_bit, r_a[WIDTH-1:1]};
                r_b     <= r_b >> 1;
                r_carry <= w_carry;
                r_cnt   <= r_cnt + CW'(1);
                if (w_last) begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_sum   <= {w_bit, r_a[WIDTH-1:1]};
                    r_cout  <= w_carry;
                end
            end else begin
                r_state <= IDLE;
            end
        end
    end
endmodule
